// File: rtl/mode_counter_pkg.sv
// mode_counter_pkg: shared encodings for the mode counter's direction and boundary mode inputs.
package mode_counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
endpackage

// File: rtl/mode_counter_prescaler.sv
// mode_counter_prescaler: divides enabled cycles by (prescale+1) into single-cycle step ticks.
module mode_counter_prescaler
  import mode_counter_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  // Lowering prescale below pre_cnt lets the counter run round through 2^PRESCALE_W.
  always_comb begin
    tick      = en && (pre_cnt_q == prescale);
    pre_cnt_d = (clr || tick) ? '0 : en ? pre_cnt_q + 1'b1 : pre_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end
endmodule

// File: rtl/mode_counter.sv
// mode_counter: prescaled up/down counter with wrap/saturate bounds, parallel load and tc/ovf flags.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8,
  parameter int RESET_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_flag,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  at_bound
);
  logic [WIDTH-1:0] count_q, count_d, next_up, next_dn;
  logic             tc_q, tc_d, ovf_q, ovf_d;
  logic             tick, step, at_top, at_zero, bound_ev;

  mode_counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  // A loaded value above limit counts as "at top" so an up step folds it back into range.
  always_comb begin
    step     = tick & ~load;
    at_top   = count_q >= limit;
    at_zero  = count_q == '0;
    at_bound = (up_dn == DIR_DN) ? at_zero : at_top;
    bound_ev = step & at_bound;
    next_up  = at_top ? ((mode == MODE_SAT) ? limit : '0) : count_q + 1'b1;
    next_dn  = at_zero ? ((mode == MODE_WRAP) ? limit : '0) : count_q - 1'b1;
    count_d  = load ? load_val : step ? ((up_dn == DIR_UP) ? next_up : next_dn) : count_q;
    tc_d     = bound_ev;
    ovf_d    = bound_ev | (ovf_q & ~clr_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= WIDTH'(RESET_VAL);
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed plus random stimulus checked against an integer reference model.
module tb_mode_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, up_dn = 1'b1, mode = 1'b0, load = 1'b0, clr_flag = 1'b0;
  logic [3:0] load_val = '0, limit = 4'd15, count;
  logic [7:0] prescale = '0;
  logic       tc, ovf, at_bound;
  int         n_chk = 0, n_fail = 0;
  int         m_cnt = 0, m_pre = 0, m_tc = 0, m_ovf = 0;

  mode_counter #(.WIDTH(4), .PRESCALE_W(8), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .prescale(prescale), .clr_flag(clr_flag),
    .count(count), .tc(tc), .ovf(ovf), .at_bound(at_bound)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: one clock edge expressed directly as the counter's behavioural rules.
  task automatic model_edge();
    bit tk, ev;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
      return;
    end
    tk = en && (m_pre == int'(prescale));
    ev = 0;
    if (load) begin
      m_cnt = int'(load_val);
      m_pre = 0;
    end else begin
      if (en) m_pre = tk ? 0 : (m_pre + 1) % 256;
      if (tk && up_dn) begin
        if (m_cnt >= int'(limit)) begin ev = 1; m_cnt = mode ? int'(limit) : 0; end
        else m_cnt = m_cnt + 1;
      end else if (tk) begin
        if (m_cnt == 0) begin ev = 1; m_cnt = mode ? 0 : int'(limit); end
        else m_cnt = m_cnt - 1;
      end
    end
    m_tc  = ev;
    m_ovf = ev ? 1 : (clr_flag ? 0 : m_ovf);
  endtask

  task automatic cyc(input string tag, input bit chk_ab = 1);
    #1;
    if (chk_ab) chk({tag, ".at_bound"}, int'(at_bound), up_dn ? int'(m_cnt >= int'(limit)) : int'(m_cnt == 0));
    model_edge();
    @(posedge clk); #1;
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".tc"}, int'(tc), m_tc);
    chk({tag, ".ovf"}, int'(ovf), m_ovf);
  endtask

  initial begin
    @(posedge clk); #1;
    rst = 1; cyc("reset", 0); rst = 0;
    chk("reset.count0", int'(count), 0);
    // 1: full up-wrap sweep
    en = 1; up_dn = 1; mode = 0; limit = 15; prescale = 0;
    for (int i = 0; i < 17; i++) cyc("t1_upwrap");
    chk("t1.ovf_sticky", int'(ovf), 1);
    // 2: saturate at 9, then clear ovf with no step pending
    mode = 1; limit = 9;
    for (int i = 0; i < 12; i++) cyc("t2_sat");
    chk("t2.count_sat", int'(count), 9);
    en = 0; clr_flag = 1; cyc("t2_clr"); clr_flag = 0;
    chk("t2.ovf_cleared", int'(ovf), 0);
    // 3: prescale with an enable gap
    mode = 0; limit = 15; prescale = 2; load_val = 0; load = 1; cyc("t3_load"); load = 0; en = 1;
    for (int i = 0; i < 6; i++) cyc("t3_pre_a");
    en = 0; for (int i = 0; i < 2; i++) cyc("t3_gap");
    en = 1; for (int i = 0; i < 7; i++) cyc("t3_pre_b");
    chk("t3.count_after_15", int'(count), 4);
    // 4: down-wrap from 2 with limit 5
    up_dn = 0; limit = 5; prescale = 0; load_val = 2; load = 1; cyc("t4_load"); load = 0;
    for (int i = 0; i < 4; i++) cyc("t4_dnwrap");
    chk("t4.count_end", int'(count), 4);
    // 5: load above limit, then load colliding with a tick
    up_dn = 1; limit = 9; load_val = 12; load = 1; cyc("t5_load"); load = 0;
    cyc("t5_fold");
    chk("t5.fold_tc", int'(tc), 1);
    prescale = 1; cyc("t5_pre1");
    load_val = 6; load = 1; cyc("t5_load_tick"); load = 0;
    chk("t5.load_wins", int'(count), 6);
    cyc("t5_pre_restart"); cyc("t5_pre_step");
    // 6: reset mid-run, then set-wins on ovf
    prescale = 0; limit = 15; load_val = 15; load = 1; cyc("t6_load"); load = 0;
    for (int i = 0; i < 8; i++) cyc("t6_run");
    chk("t6.count7", int'(count), 7);
    rst = 1; cyc("t6_rst"); rst = 0;
    chk("t6.rst_ovf", int'(ovf), 0);
    limit = 9; load_val = 9; load = 1; cyc("t6_load9"); load = 0;
    clr_flag = 1; cyc("t6_setwins"); clr_flag = 0;
    chk("t6.setwins_ovf", int'(ovf), 1);
    // random
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1);
      mode     = $urandom_range(0, 1);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom);
      limit    = 4'($urandom_range(0, 15));
      prescale = 8'($urandom_range(0, 3));
      clr_flag = ($urandom_range(0, 7) == 0);
      cyc("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
